// File: rtl/cmd_uart_tx.sv
// rtl/cmd_uart_tx.sv - car-link command encoder and UART 8N1 transmitter
//
// Encodes the operator controls into the one-byte car command and sends it
// LSB first as 8N1. A frame goes out when the encoded byte differs from the
// last one sent, and as a keepalive KEEPALIVE_CYC cycles after the previous
// frame start. The first frame after reset is always sent.
//
// Ports:
//   clk        system clock
//   rst        asynchronous active-high reset
//   sel_mode   drive mode select (0..7)
//   speed      speed level
//   steer_dir  steering direction, used in mode 0 only (11 masked to hold)
//   step       steering step size
//   tx         serial line, idle high
//   busy       high from start bit through end of stop bit
//   tx_done    one-cycle pulse after the stop bit completes
//   sent_byte  byte of the frame in progress or the last one sent

module cmd_uart_tx #(
    parameter int CLK_FRE       = 24_000_000,
    parameter int BAUD          = 9600,
    parameter int KEEPALIVE_CYC = 2_400_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] sel_mode,
    input  logic [1:0] speed,
    input  logic [1:0] steer_dir,
    input  logic [1:0] step,
    output logic       tx,
    output logic       busy,
    output logic       tx_done,
    output logic [7:0] sent_byte
);

    localparam int BAUD_DIV = CLK_FRE / BAUD;
    localparam int BW       = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int KW       = (KEEPALIVE_CYC > 1) ? $clog2(KEEPALIVE_CYC) : 1;

    localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
    localparam logic [KW-1:0] KA_LAST   = KW'(KEEPALIVE_CYC - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_START = 2'd1;
    localparam logic [1:0] S_DATA  = 2'd2;
    localparam logic [1:0] S_STOP  = 2'd3;

    logic [7:0]    cmd_byte_d, cmd_byte_q;
    logic [1:0]    steer_m;
    logic [1:0]    state_d, state_q;
    logic [BW-1:0] baud_d, baud_q;
    logic [2:0]    bit_d, bit_q;
    logic [7:0]    shift_d, shift_q;
    logic [7:0]    last_d, last_q;
    logic [7:0]    sent_d, sent_q;
    logic [KW-1:0] ka_d, ka_q;
    logic          force_d, force_q;
    logic          busy_d, busy_q;
    logic          done_d, done_q;
    logic          tx_d, tx_q;
    logic          baud_done;
    logic          trigger;

    // Command encoder
    always_comb begin
        steer_m    = (steer_dir == 2'b11) ? 2'b00 : steer_dir;
        cmd_byte_d = 8'h80;
        case (sel_mode)
            3'd0:    cmd_byte_d = {4'b0011, steer_m, step};
            3'd1:    cmd_byte_d = {4'b0111, speed, 2'b00};
            3'd2:    cmd_byte_d = {4'b0110, speed, 2'b00};
            3'd3:    cmd_byte_d = {4'b0101, speed, step};
            3'd4:    cmd_byte_d = {4'b0100, speed, step};
            3'd6:    cmd_byte_d = {4'b1111, 2'b00, speed};
            default: cmd_byte_d = 8'h80;
        endcase
    end

    // Left out of reset on purpose: it keeps tracking the inputs while rst is
    // held, so the first frame after release carries the current command.
    always_ff @(posedge clk) begin
        cmd_byte_q <= cmd_byte_d;
    end

    assign baud_done = (baud_q == BAUD_LAST);
    assign trigger   = force_q | (cmd_byte_q != last_q) | (ka_q == KA_LAST);

    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 1'b1;
        bit_d   = bit_q;
        shift_d = shift_q;
        last_d  = last_q;
        sent_d  = sent_q;
        ka_d    = (ka_q == KA_LAST) ? ka_q : ka_q + 1'b1;
        force_d = force_q;
        busy_d  = busy_q;
        done_d  = 1'b0;

        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (trigger) begin
                    state_d = S_START;
                    shift_d = cmd_byte_q;
                    last_d  = cmd_byte_q;
                    sent_d  = cmd_byte_q;
                    ka_d    = '0;
                    force_d = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (baud_done) begin
                    state_d = S_DATA;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                end
            end
            S_DATA: begin
                if (baud_done) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
            default: begin
                if (baud_done) begin
                    state_d = S_IDLE;
                    baud_d  = '0;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
        endcase

        // Line level is registered from the next state so tx is glitch-free
        // and the start bit appears on the same edge that enters START.
        tx_d = 1'b1;
        if (state_d == S_START) begin
            tx_d = 1'b0;
        end else if (state_d == S_DATA) begin
            tx_d = shift_d[0];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            last_q  <= 8'h80;
            sent_q  <= 8'h80;
            ka_q    <= '0;
            force_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            last_q  <= last_d;
            sent_q  <= sent_d;
            ka_q    <= ka_d;
            force_q <= force_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            tx_q    <= tx_d;
        end
    end

    assign tx        = tx_q;
    assign busy      = busy_q;
    assign tx_done   = done_q;
    assign sent_byte = sent_q;

endmodule

// File: tb/tb_cmd_uart_tx.sv
// tb/tb_cmd_uart_tx.sv - directed self-checking bench for cmd_uart_tx

module tb_cmd_uart_tx;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [2:0] sel_mode = 3'd5;
    logic [1:0] speed = 2'b00;
    logic [1:0] steer_dir = 2'b00;
    logic [1:0] step = 2'b00;
    logic       tx;
    logic       busy;
    logic       tx_done;
    logic [7:0] sent_byte;

    int n_cmp = 0;
    int n_fail = 0;

    cmd_uart_tx #(
        .CLK_FRE      (240),
        .BAUD         (24),
        .KEEPALIVE_CYC(300)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .sel_mode (sel_mode),
        .speed    (speed),
        .steer_dir(steer_dir),
        .step     (step),
        .tx       (tx),
        .busy     (busy),
        .tx_done  (tx_done),
        .sent_byte(sent_byte)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    // Waits (from a negedge) for busy, then samples the frame mid-bit.
    // timing = {tx_done,busy} at the last stop cycle, {tx_done,busy} one
    // cycle later, then tx_done one more cycle later; expected 5'b01100.
    task automatic capture_frame(input int max_wait, output bit ok, output int waited,
                                 output logic [9:0] bits, output logic [7:0] sb,
                                 output logic [4:0] timing);
        ok = 1'b1; waited = 0; bits = '0; sb = '0; timing = '0;
        while (busy !== 1'b1 && waited < max_wait) begin
            @(negedge clk);
            waited++;
        end
        if (busy !== 1'b1) begin
            ok = 1'b0;
            return;
        end
        sb = sent_byte;
        for (int k = 0; k < 10; k++) begin
            repeat ((k == 0) ? 5 : 10) @(negedge clk);
            bits[k] = tx;
        end
        repeat (4) @(negedge clk);
        timing[4] = tx_done; timing[3] = busy;
        @(negedge clk);
        timing[2] = tx_done; timing[1] = busy;
        @(negedge clk);
        timing[0] = tx_done;
    endtask

    task automatic test_reset();
        bit ok; int w; logic [9:0] b; logic [7:0] sb; logic [4:0] t;
        repeat (3) @(negedge clk);
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rst_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
        n_cmp++; if (tx_done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", tx_done); end
        n_cmp++; if (sent_byte !== 8'h80) begin n_fail++; $display("FAIL rst_sent: got %h want 80", sent_byte); end
        rst = 1'b0;
        capture_frame(5, ok, w, b, sb, t);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL rst_frame: no frame start within 5 cycles");
            return;
        end
        n_cmp++; if (w < 1 || w > 2) begin n_fail++; $display("FAIL rst_latency: got %0d want 1..2", w); end
        n_cmp++; if (sb !== 8'h80) begin n_fail++; $display("FAIL rst_byte: got %h want 80", sb); end
        n_cmp++; if (b !== 10'b11_0000_0000) begin n_fail++; $display("FAIL rst_bits: got %b want 1100000000", b); end
        n_cmp++; if (t !== 5'b01100) begin n_fail++; $display("FAIL rst_done_timing: got %b want 01100", t); end
    endtask

    task automatic test_encode();
        // {sel_mode, speed, steer_dir, step, expected byte}
        logic [16:0] vec [8];
        bit ok; int w; logic [9:0] b; logic [7:0] sb; logic [4:0] t; logic [7:0] e;
        vec[0] = {3'd1, 2'b10, 2'b00, 2'b00, 8'h78};
        vec[1] = {3'd6, 2'b11, 2'b00, 2'b00, 8'hF3};
        vec[2] = {3'd0, 2'b00, 2'b11, 2'b10, 8'h32};
        vec[3] = {3'd0, 2'b00, 2'b10, 2'b01, 8'h39};
        vec[4] = {3'd2, 2'b01, 2'b00, 2'b00, 8'h64};
        vec[5] = {3'd3, 2'b11, 2'b00, 2'b01, 8'h5D};
        vec[6] = {3'd4, 2'b10, 2'b00, 2'b11, 8'h4B};
        vec[7] = {3'd7, 2'b00, 2'b00, 2'b00, 8'h80};
        for (int i = 0; i < 8; i++) begin
            sel_mode = vec[i][16:14]; speed = vec[i][13:12];
            steer_dir = vec[i][11:10]; step = vec[i][9:8];
            e = vec[i][7:0];
            capture_frame(20, ok, w, b, sb, t);
            n_cmp++;
            if (!ok) begin
                n_fail++; $display("FAIL enc[%0d]: no frame start", i);
                return;
            end
            n_cmp++; if (w != 2) begin n_fail++; $display("FAIL enc_latency[%0d]: got %0d want 2", i, w); end
            n_cmp++; if (sb !== e) begin n_fail++; $display("FAIL enc_byte[%0d]: got %h want %h", i, sb, e); end
            n_cmp++; if (b !== {1'b1, e, 1'b0}) begin n_fail++; $display("FAIL enc_bits[%0d]: got %b want %b", i, b, {1'b1, e, 1'b0}); end
            n_cmp++; if (t !== 5'b01100) begin n_fail++; $display("FAIL enc_timing[%0d]: got %b want 01100", i, t); end
        end
    endtask

    task automatic test_keepalive();
        bit ok; int w; logic [9:0] b; logic [7:0] sb; logic [4:0] t;
        for (int i = 0; i < 2; i++) begin
            // previous capture ended 101 cycles after its start edge
            capture_frame(400, ok, w, b, sb, t);
            n_cmp++;
            if (!ok) begin
                n_fail++; $display("FAIL ka[%0d]: no keepalive frame", i);
                return;
            end
            n_cmp++; if (w != 199) begin n_fail++; $display("FAIL ka_gap[%0d]: got %0d want 199", i, w); end
            n_cmp++; if (sb !== 8'h80 || b !== 10'b11_0000_0000) begin n_fail++; $display("FAIL ka_frame[%0d]: got %h/%b want 80/1100000000", i, sb, b); end
        end
    endtask

    task automatic test_back_to_back();
        bit ok; int w; logic [9:0] b; logic [7:0] sb; logic [4:0] t;
        sel_mode = 3'd3; speed = 2'b11; step = 2'b01; steer_dir = 2'b00;
        fork
            capture_frame(20, ok, w, b, sb, t);
            begin
                repeat (30) @(negedge clk);
                sel_mode = 3'd4;
                repeat (30) @(negedge clk);
                sel_mode = 3'd1; speed = 2'b10;
            end
        join
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_frame: no frame start");
            return;
        end
        n_cmp++; if (sb !== 8'h5D || b !== {1'b1, 8'h5D, 1'b0}) begin n_fail++; $display("FAIL mid_inflight: got %h/%b want 5d/1010111010", sb, b); end
        capture_frame(20, ok, w, b, sb, t);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL mid_follow: no following frame");
            return;
        end
        n_cmp++; if (w != 0) begin n_fail++; $display("FAIL b2b_gap: got %0d want 0", w); end
        n_cmp++; if (sb !== 8'h78 || b !== {1'b1, 8'h78, 1'b0}) begin n_fail++; $display("FAIL mid_latest: got %h/%b want 78/1011110000", sb, b); end
        capture_frame(400, ok, w, b, sb, t);
        n_cmp++; if (!ok || w != 199 || sb !== 8'h78) begin n_fail++; $display("FAIL mid_single: got ok=%0d gap=%0d byte=%h want 1/199/78", ok, w, sb); end
    endtask

    task automatic test_reset_mid_frame();
        bit ok; int w; logic [9:0] b; logic [7:0] sb; logic [4:0] t;
        sel_mode = 3'd2; speed = 2'b01;
        w = 0;
        while (busy !== 1'b1 && w < 20) begin
            @(negedge clk);
            w++;
        end
        n_cmp++;
        if (busy !== 1'b1) begin
            n_fail++; $display("FAIL rmid_start: no frame start");
            return;
        end
        repeat (55) @(negedge clk);
        n_cmp++; if (tx !== 1'b0) begin n_fail++; $display("FAIL rmid_bit4: got %b want 0", tx); end
        rst = 1'b1;
        #1;
        n_cmp++; if (tx !== 1'b1) begin n_fail++; $display("FAIL rmid_tx: got %b want 1", tx); end
        n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rmid_busy: got %b want 0", busy); end
        repeat (3) @(negedge clk);
        rst = 1'b0;
        capture_frame(5, ok, w, b, sb, t);
        n_cmp++;
        if (!ok) begin
            n_fail++; $display("FAIL rmid_resend: no frame after reset");
            return;
        end
        n_cmp++; if (w != 1) begin n_fail++; $display("FAIL rmid_latency: got %0d want 1", w); end
        n_cmp++; if (sb !== 8'h64 || b !== {1'b1, 8'h64, 1'b0}) begin n_fail++; $display("FAIL rmid_frame: got %h/%b want 64/1011001000", sb, b); end
        n_cmp++; if (t !== 5'b01100) begin n_fail++; $display("FAIL rmid_timing: got %b want 01100", t); end
    endtask

    initial begin
        test_reset();
        test_encode();
        test_keepalive();
        test_back_to_back();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
